// File: rtl/mips_hazard_scoreboard_if.sv
// ---------------------------------------------------------------------------
// mips_hazard_scoreboard_if
// Bundles the ID-stage view of the hazard scoreboard: the decoded
// instruction fields, the branch flush, and the interlock/forwarding
// results returned to the pipeline.
//
// Parameters : REG_ADDR_W (register index width), WB_LATENCY (in-flight
//              slots, sets the forward-slot width), CNT_W (stall counter)
// master     : drives id_* and flush, observes stall/fwd_*/stall_cycles
// slave      : the scoreboard itself
// ---------------------------------------------------------------------------
interface mips_hazard_scoreboard_if #(
    parameter int REG_ADDR_W = 5,
    parameter int WB_LATENCY = 3,
    parameter int CNT_W      = 16
);
    localparam int SLOT_W = (WB_LATENCY > 1) ? $clog2(WB_LATENCY) : 1;

    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_rs;
    logic [REG_ADDR_W-1:0] id_rt;
    logic                  id_rs_used;
    logic                  id_rt_used;
    logic [REG_ADDR_W-1:0] id_rd;
    logic                  id_rd_wr;
    logic                  id_is_load;
    logic                  flush;
    logic                  stall;
    logic                  fwd_rs_hit;
    logic                  fwd_rt_hit;
    logic [SLOT_W-1:0]     fwd_rs_slot;
    logic [SLOT_W-1:0]     fwd_rt_slot;
    logic [CNT_W-1:0]      stall_cycles;

    modport master (
        output id_valid, id_rs, id_rt, id_rs_used, id_rt_used,
               id_rd, id_rd_wr, id_is_load, flush,
        input  stall, fwd_rs_hit, fwd_rt_hit, fwd_rs_slot, fwd_rt_slot,
               stall_cycles
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_rs_used, id_rt_used,
               id_rd, id_rd_wr, id_is_load, flush,
        output stall, fwd_rs_hit, fwd_rt_hit, fwd_rs_slot, fwd_rt_slot,
               stall_cycles
    );
endinterface

// File: rtl/mips_hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// mips_hazard_scoreboard
// Register-hazard interlock for the pipe_MIPS32 family. Tracks the
// destination registers of the last WB_LATENCY issued instructions in a
// shift register of slots and stalls ID while it would read a register
// that has not been written back yet. Optionally reports forwarding
// sources instead of stalling (macro MIPS_HAZARD_FORWARD_EN); when the
// macro is undefined the design is a full interlock and fwd_* are 0.
//
// Ports:
//   clk    : pipeline clock, all state updates on the rising edge
//   rst_n  : asynchronous active-low reset (clears slots and counter)
//   hz     : slave side of mips_hazard_scoreboard_if
//            id_* / flush in; stall, fwd_* (combinational) and the
//            saturating stall_cycles counter (registered) out
// ---------------------------------------------------------------------------
module mips_hazard_scoreboard #(
    parameter int REG_ADDR_W  = 5,
    parameter int WB_LATENCY  = 3,
    parameter int FLUSH_SLOTS = 2,
    parameter int CNT_W       = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    mips_hazard_scoreboard_if.slave        hz
);
    localparam int SLOT_W = (WB_LATENCY > 1) ? $clog2(WB_LATENCY) : 1;

    // Slot k is the instruction issued k+1 cycles ago.
    logic [WB_LATENCY-1:0]                 valid_q, valid_d;
    logic [WB_LATENCY-1:0][REG_ADDR_W-1:0] rd_q, rd_d;
    logic [CNT_W-1:0]                      cnt_q, cnt_d;

    logic [WB_LATENCY-1:0]                 match_rs_s;
    logic [WB_LATENCY-1:0]                 match_rt_s;
    logic                                  hazard_s;
    logic                                  stall_s;
    logic                                  issue_s;
    logic                                  fwd_rs_hit_s;
    logic                                  fwd_rt_hit_s;
    logic [SLOT_W-1:0]                     fwd_rs_slot_s;
    logic [SLOT_W-1:0]                     fwd_rt_slot_s;

`ifdef MIPS_HAZARD_FORWARD_EN
    // Only the youngest slot's load flag can ever cause a stall (a load
    // one slot older is already forwardable), so it is the only one kept.
    logic                                  s0_load_q, s0_load_d;
`endif

    // Per-slot source comparison; R0 is hard-wired and never a hazard.
    always_comb begin
        match_rs_s = '0;
        match_rt_s = '0;
        for (int k = 0; k < WB_LATENCY; k++) begin
            match_rs_s[k] = hz.id_rs_used & (hz.id_rs != '0) & valid_q[k]
                            & (rd_q[k] == hz.id_rs);
            match_rt_s[k] = hz.id_rt_used & (hz.id_rt != '0) & valid_q[k]
                            & (rd_q[k] == hz.id_rt);
        end
    end

`ifdef MIPS_HAZARD_FORWARD_EN
    // Forwarding mode: only a load in slot 0 interlocks; other matches
    // forward from the youngest matching producer.
    always_comb begin
        hazard_s      = (match_rs_s[0] | match_rt_s[0]) & s0_load_q;
        fwd_rs_slot_s = '0;
        fwd_rt_slot_s = '0;
        // Scan oldest to youngest so the lowest matching k wins.
        for (int k = WB_LATENCY - 1; k >= 0; k--) begin
            fwd_rs_slot_s = match_rs_s[k] ? SLOT_W'(k) : fwd_rs_slot_s;
            fwd_rt_slot_s = match_rt_s[k] ? SLOT_W'(k) : fwd_rt_slot_s;
        end
        fwd_rs_hit_s  = (|match_rs_s) & ~hazard_s;
        fwd_rt_hit_s  = (|match_rt_s) & ~hazard_s;
    end
`else
    // Full interlock: any pending producer of a used source stalls ID.
    always_comb begin
        hazard_s      = (|match_rs_s) | (|match_rt_s);
        fwd_rs_hit_s  = 1'b0;
        fwd_rt_hit_s  = 1'b0;
        fwd_rs_slot_s = '0;
        fwd_rt_slot_s = '0;
    end
`endif

    // Stall/issue decision; a flush overrides both.
    always_comb begin
        stall_s = hz.id_valid & ~hz.flush & hazard_s;
        issue_s = hz.id_valid & ~stall_s & ~hz.flush;
    end

    // Next slot state: kill young slots on flush, then shift and insert.
    always_comb begin
        valid_d = '0;
        rd_d    = '0;
        if (issue_s) begin
            valid_d[0] = hz.id_rd_wr & (hz.id_rd != '0);
            rd_d[0]    = hz.id_rd;
        end else begin
            valid_d[0] = 1'b0;
            rd_d[0]    = '0;
        end
        for (int k = 1; k < WB_LATENCY; k++) begin
            valid_d[k] = valid_q[k-1] & ~(hz.flush & ((k - 1) < FLUSH_SLOTS));
            rd_d[k]    = rd_q[k-1];
        end
    end

`ifdef MIPS_HAZARD_FORWARD_EN
    // Load flag of the instruction entering slot 0.
    always_comb begin
        if (issue_s) begin
            s0_load_d = hz.id_is_load;
        end else begin
            s0_load_d = 1'b0;
        end
    end
`endif

    // Saturating stall-cycle counter next state.
    always_comb begin
        if (stall_s && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Slot and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef MIPS_HAZARD_FORWARD_EN
    // Slot-0 load flag register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_load_q <= 1'b0;
        end else begin
            s0_load_q <= s0_load_d;
        end
    end
`endif

    assign hz.stall        = stall_s;
    assign hz.fwd_rs_hit   = fwd_rs_hit_s;
    assign hz.fwd_rt_hit   = fwd_rt_hit_s;
    assign hz.fwd_rs_slot  = fwd_rs_slot_s;
    assign hz.fwd_rt_slot  = fwd_rt_slot_s;
    assign hz.stall_cycles = cnt_q;

endmodule

// File: tb/tb_mips_hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_mips_hazard_scoreboard
// Directed bench for mips_hazard_scoreboard. Two instances share the same
// ID stimulus: the default configuration and one with a 4-bit stall counter
// for the saturation case. Expected values are hand-derived for whichever
// mode (MIPS_HAZARD_FORWARD_EN defined or not) the bench is built in.
// ---------------------------------------------------------------------------
module tb_mips_hazard_scoreboard;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mips_hazard_scoreboard_if #(.REG_ADDR_W(5), .WB_LATENCY(3), .CNT_W(16)) bus ();
    mips_hazard_scoreboard_if #(.REG_ADDR_W(5), .WB_LATENCY(3), .CNT_W(4))  bus_s ();

    mips_hazard_scoreboard #(
        .REG_ADDR_W(5), .WB_LATENCY(3), .FLUSH_SLOTS(2), .CNT_W(16)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (bus.slave)
    );

    mips_hazard_scoreboard #(
        .REG_ADDR_W(5), .WB_LATENCY(3), .FLUSH_SLOTS(2), .CNT_W(4)
    ) u_dut_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (bus_s.slave)
    );

    // Compare one observed value against its expected value.
    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Present one decoded instruction to both instances.
    task automatic set_id(input logic v, input logic [4:0] rs, input logic rs_u,
                          input logic [4:0] rt, input logic rt_u,
                          input logic [4:0] rd, input logic rd_w,
                          input logic ld, input logic fl);
        bus.id_valid   = v;    bus_s.id_valid   = v;
        bus.id_rs      = rs;   bus_s.id_rs      = rs;
        bus.id_rs_used = rs_u; bus_s.id_rs_used = rs_u;
        bus.id_rt      = rt;   bus_s.id_rt      = rt;
        bus.id_rt_used = rt_u; bus_s.id_rt_used = rt_u;
        bus.id_rd      = rd;   bus_s.id_rd      = rd;
        bus.id_rd_wr   = rd_w; bus_s.id_rd_wr   = rd_w;
        bus.id_is_load = ld;   bus_s.id_is_load = ld;
        bus.flush      = fl;   bus_s.flush      = fl;
    endtask

    task automatic idle();
        set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // Advance past the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        idle();
        repeat (4) cyc();
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("reset_stall", bus.stall, 1'b0);
        check_eq("reset_fwd_rs", bus.fwd_rs_hit, 1'b0);
        check_eq("reset_cnt", bus.stall_cycles, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // ADDI R10,R0,200 then LW R3,0(R10)
        set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        check_eq("addi_stall", bus.stall, 1'b0);
        cyc();
        set_id(1'b1, 5'd10, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0);
`ifdef MIPS_HAZARD_FORWARD_EN
        @(negedge clk);
        check_eq("lw_fwd_stall", bus.stall, 1'b0);
        check_eq("lw_fwd_rs_hit", bus.fwd_rs_hit, 1'b1);
        check_eq("lw_fwd_rs_slot", bus.fwd_rs_slot, 32'd0);
        check_eq("lw_fwd_rt_hit", bus.fwd_rt_hit, 1'b0);
        cyc();
        @(negedge clk);
        check_eq("lw_fwd_cnt", bus.stall_cycles, 32'd0);
`else
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq($sformatf("lw_stall_%0d", i), bus.stall, 1'b1);
            check_eq($sformatf("lw_fwd_off_%0d", i), bus.fwd_rs_hit, 1'b0);
            cyc();
        end
        @(negedge clk);
        check_eq("lw_issue", bus.stall, 1'b0);
        check_eq("lw_cnt", bus.stall_cycles, 32'd3);
        cyc();
`endif
        drain();

        // LW R3,0(R10) then MUL R2,R2,R3
        set_id(1'b1, 5'd10, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        check_eq("lw2_stall", bus.stall, 1'b0);
        cyc();
        set_id(1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 5'd2, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        check_eq("mul_stall_0", bus.stall, 1'b1);
        check_eq("mul_rt_hit_0", bus.fwd_rt_hit, 1'b0);
        cyc();
        @(negedge clk);
`ifdef MIPS_HAZARD_FORWARD_EN
        check_eq("mul_stall_1", bus.stall, 1'b0);
        check_eq("mul_rt_hit_1", bus.fwd_rt_hit, 1'b1);
        check_eq("mul_rt_slot_1", bus.fwd_rt_slot, 32'd1);
        check_eq("mul_rs_hit_1", bus.fwd_rs_hit, 1'b0);
`else
        check_eq("mul_stall_1", bus.stall, 1'b1);
        check_eq("mul_rt_hit_1", bus.fwd_rt_hit, 1'b0);
`endif
        cyc();
        drain();

        // ADDI R0,R0,5 then OR R4,R0,R0: R0 never a hazard
        set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
        cyc();
        set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        check_eq("r0_stall", bus.stall, 1'b0);
        check_eq("r0_rs_hit", bus.fwd_rs_hit, 1'b0);
        check_eq("r0_rt_hit", bus.fwd_rt_hit, 1'b0);
        cyc();
        drain();

        // SUBI R3,R3,1; flush with a wrong-path reader of R3; BNEQZ R3
        set_id(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        check_eq("subi_stall", bus.stall, 1'b0);
        cyc();
        set_id(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        check_eq("flush_stall", bus.stall, 1'b0);
        cyc();
        set_id(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check_eq("bneqz_stall", bus.stall, 1'b0);
        check_eq("bneqz_rs_hit", bus.fwd_rs_hit, 1'b0);
        cyc();
        drain();

        // Three producers (R5, R6, LW R7) pending, then async reset
        set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
        cyc();
        set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0);
        cyc();
        set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0);
        cyc();
        set_id(1'b1, 5'd7, 1'b1, 5'd6, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        check_eq("pend_stall", bus.stall, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_stall", bus.stall, 1'b0);
        check_eq("arst_cnt", bus.stall_cycles, 32'd0);
        check_eq("arst_rt_hit", bus.fwd_rt_hit, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_eq("post_rst_stall", bus.stall, 1'b0);
        cyc();
        drain();

        // Self-dependent LW R1,0(R1) held in ID: repeated stalls
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd1, 1'b1, 1'b1, 1'b0);
        repeat (40) cyc();
        @(negedge clk);
`ifdef MIPS_HAZARD_FORWARD_EN
        check_eq("rep_cnt_full", bus.stall_cycles, 32'd20);
`else
        check_eq("rep_cnt_full", bus.stall_cycles, 32'd30);
`endif
        check_eq("sat_cnt", bus_s.stall_cycles, 32'd15);
        cyc();
        repeat (8) cyc();
        @(negedge clk);
        check_eq("sat_cnt_hold", bus_s.stall_cycles, 32'd15);
        idle();
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
